wptr_full: RTL and testbench
============================

// Module: wptr_full
// PURPOSE
//  Write-domain pointer and full-flag generator for the team's async FIFO. Pairs with the
//  read-side empty/pointer block. Sits in the wclk domain between the write client and the
//  dual-port memory. Outputs: memory write address, write pointer for sync to the read domain,
//  registered full, fill-level estimate, sticky overflow flag.
// PARAMETERS
//  ASIZE        32  address width; FIFO depth = 2**ASIZE; pointers are ASIZE+1 bits
//  AFULL_THRESH 2   almost-full asserts when free slots <= AFULL_THRESH (used only with WFULL_ALMOST_EN)
// PORTS
//  wclk        in   1        write clock
//  wrst_n      in   1        asynchronous active-low reset
//  w_en        in   1        write request from client
//  wsync_rptr  in   ASIZE+1  read pointer already synchronised into wclk (binary, same encoding as wptr)
//  wovf_clr    in   1        clears woverflow
//  wfull       out  1        FIFO full, registered
//  waddr       out  ASIZE    memory write address = wptr[ASIZE-1:0]
//  wptr        out  ASIZE+1  binary write pointer, registered, crosses to read domain
//  wlevel      out  ASIZE+1  occupied entries as seen from write domain, registered, 0..2**ASIZE
//  woverflow   out  1        sticky: write attempted while full
//  wafull      out  1        almost-full, registered (constant 0 without WFULL_ALMOST_EN)
// BEHAVIOUR
//  - Reset (wrst_n=0, async, immediate): wptr=0, wfull=0, wlevel=0, woverflow=0, wafull=0.
//  - winc = w_en & ~wfull; next_wptr = wptr + winc, modulo 2**(ASIZE+1). wptr <= next_wptr each wclk.
//  - waddr combinational from wptr; memory writes at waddr when winc=1 on that same edge.
//  - next_wfull = (next_wptr == {~wsync_rptr[ASIZE], wsync_rptr[ASIZE-1:0]}); wfull <= next_wfull.
//    Full asserts on the edge that accepts the last free slot (zero-cycle lag).
//  - Full is pessimistic: deasserts only on the edge after wsync_rptr advances.
//  - Write while full: ignored; wptr/waddr unchanged; no memory write.
//  - wlevel <= next_wptr - wsync_rptr (ASIZE+1-bit modular subtract); = 2**ASIZE when full.
//  - woverflow: set on edge where w_en & wfull; cleared by wovf_clr; set wins if both in same cycle.
//  - Wrap-around: MSB of wptr toggles each full traversal; low bits wrap to 0; no special handling.
//  - w_en held high continuously: one write per cycle until full, then stalls with no glitch on wfull.
//  - Reset mid-operation: all state cleared immediately, FIFO contents are discarded logically;
//    read side must be reset concurrently (system requirement, not checked here).
//  - No combinational path from wsync_rptr to any output; all outputs except waddr are flops.
// CONFIGURATION
//  WFULL_ALMOST_EN defined: wafull <= (next level >= 2**ASIZE - AFULL_THRESH), registered,
//    same update edge as wfull; deasserts when level falls below threshold.
//  WFULL_ALMOST_EN undefined: wafull tied to 1'b0; threshold logic not built; AFULL_THRESH ignored.
// TESTING  (ASIZE=2, depth 4)
//  1 Reset: wrst_n=0 mid-cycle -> wptr=0, waddr=0, wfull=0, wlevel=0, woverflow=0, wafull=0 at once.
//  2 Fill: wsync_rptr=3'b000, w_en=1 for 4 edges -> waddr 0,1,2,3; after 4th edge wptr=3'b100,
//    wfull=1, wlevel=4.
//  3 Overflow: full, w_en=1 for 2 edges -> wptr stays 3'b100, woverflow=1; wovf_clr=1 -> woverflow=0;
//    wovf_clr=1 with w_en=1 while full -> woverflow=1.
//  4 Drain/wrap: full, set wsync_rptr=3'b100 -> wfull=0, wlevel=0 next edge; 4 writes -> wptr
//    3'b101,110,111,000; wfull=1 after 4th.
//  5 Almost-full: WFULL_ALMOST_EN, AFULL_THRESH=1, wsync_rptr=0 -> wafull=1 after 3rd write,
//    wfull=0; wsync_rptr=3'b001 -> wafull=0 next edge (level 2); macro undefined -> wafull stays 0.
//  6 Reset mid-fill: after 2 writes pulse wrst_n low between edges -> all outputs 0 immediately;
//    next write after release uses waddr=0.

Source files
------------

// File: rtl/wptr_full.sv
// Write-domain pointer / full-flag generator for the async FIFO.
// Produces the memory write address, the binary write pointer that is
// synchronised into the read domain, a registered full flag, a fill-level
// estimate and a sticky overflow flag.
// Optional feature: define WFULL_ALMOST_EN to build the registered almost-full
// flag (asserts when free slots <= AFULL_THRESH). Without it, wafull is 0.
module wptr_full #(
  parameter int unsigned ASIZE        = 32,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             w_en,
  input  logic [ASIZE:0]   wsync_rptr,
  input  logic             wovf_clr,
  output logic             wfull,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow,
  output logic             wafull
);

  logic [ASIZE:0] r_wptr;
  logic           r_wfull;
  logic [ASIZE:0] r_wlevel;
  logic           r_woverflow;

  logic           w_winc;
  logic [ASIZE:0] w_next_wptr;
  logic [ASIZE:0] w_rptr_flip;
  logic           w_next_full;
  logic [ASIZE:0] w_next_level;

  // Accept a write only while not full; full compares against the read
  // pointer with its wrap bit inverted (one full lap ahead).
  always_comb begin
    w_winc       = w_en & ~r_wfull;
    w_next_wptr  = r_wptr + {{ASIZE{1'b0}}, w_winc};
    w_rptr_flip  = {~wsync_rptr[ASIZE], wsync_rptr[ASIZE-1:0]};
    w_next_full  = (w_next_wptr == w_rptr_flip);
    w_next_level = w_next_wptr - wsync_rptr;
  end

  // Pointer, full flag and fill level, all updated on the same edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr   <= '0;
      r_wfull  <= 1'b0;
      r_wlevel <= '0;
    end else begin
      r_wptr   <= w_next_wptr;
      r_wfull  <= w_next_full;
      r_wlevel <= w_next_level;
    end
  end

  // Sticky overflow: a write attempt while full sets it; set beats clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_woverflow <= 1'b0;
    end else if (w_en && r_wfull) begin
      r_woverflow <= 1'b1;
    end else if (wovf_clr) begin
      r_woverflow <= 1'b0;
    end
  end

`ifdef WFULL_ALMOST_EN
  localparam logic [ASIZE:0] DEPTH    = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_LIMIT = DEPTH - (ASIZE+1)'(AFULL_THRESH);

  logic r_wafull;

  // Almost-full tracks the same next level that feeds wlevel.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wafull <= 1'b0;
    end else begin
      r_wafull <= (w_next_level >= AF_LIMIT);
    end
  end

  assign wafull = r_wafull;
`else
  assign wafull = 1'b0;
`endif

  assign wptr      = r_wptr;
  assign waddr     = r_wptr[ASIZE-1:0];
  assign wfull     = r_wfull;
  assign wlevel    = r_wlevel;
  assign woverflow = r_woverflow;

endmodule

// File: tb/tb_wptr_full.sv
// Bench for wptr_full (ASIZE=2, depth 4, AFULL_THRESH=1). The reference model
// counts total writes and total reads as plain integers; pointers, level and
// flags are derived from those counts. Expected results are queued by the
// stimulus process and consumed by an independent monitor.
module tb_wptr_full;

  localparam int unsigned ASIZE = 2;
  localparam int unsigned AFT   = 1;
  localparam int          DEPTH = 4;
  localparam int          PMOD  = 8;

  logic             wclk;
  logic             wrst_n;
  logic             w_en;
  logic [ASIZE:0]   wsync_rptr;
  logic             wovf_clr;
  logic             wfull;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   wlevel;
  logic             woverflow;
  logic             wafull;

  wptr_full #(.ASIZE(ASIZE), .AFULL_THRESH(AFT)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .w_en       (w_en),
    .wsync_rptr (wsync_rptr),
    .wovf_clr   (wovf_clr),
    .wfull      (wfull),
    .waddr      (waddr),
    .wptr       (wptr),
    .wlevel     (wlevel),
    .woverflow  (woverflow),
    .wafull     (wafull)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    string tag;
    int    ptr;
    int    full;
    int    level;
    int    ovf;
    int    afull;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event ev_async;

  // reference model state: total writes / reads since reset
  int m_wcnt = 0;
  int m_rcnt = 0;
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
    end
  endtask

  task automatic compare_one();
    exp_t e;
    e = q.pop_front();
    chk(e.tag, "wptr",      32'(wptr),      e.ptr);
    chk(e.tag, "waddr",     32'(waddr),     e.ptr % DEPTH);
    chk(e.tag, "wfull",     32'(wfull),     e.full);
    chk(e.tag, "wlevel",    32'(wlevel),    e.level);
    chk(e.tag, "woverflow", 32'(woverflow), e.ovf);
    chk(e.tag, "wafull",    32'(wafull),    e.afull);
  endtask

  // monitor: after every active edge, check the response queued for it
  initial begin
    forever begin
      @(posedge wclk);
      #1;
      if (q.size() != 0) compare_one();
    end
  end

  // monitor: asynchronous reset response, checked while reset is low
  initial begin
    forever begin
      @(ev_async);
      if (q.size() != 0) compare_one();
    end
  end

  function automatic exp_t model_view(input string tag);
    exp_t e;
    int   lvl;
    lvl     = m_wcnt - m_rcnt;
    e.tag   = tag;
    e.ptr   = m_wcnt % PMOD;
    e.full  = int'(m_full);
    e.level = lvl;
    e.ovf   = int'(m_ovf);
`ifdef WFULL_ALMOST_EN
    e.afull = (lvl >= DEPTH - int'(AFT)) ? 1 : 0;
`else
    e.afull = 0;
`endif
    return e;
  endfunction

  // one write-clock cycle: drive at the falling edge, predict the next edge
  task automatic cycle(input bit we, input int radv, input bit clr,
                       input string tag);
    @(negedge wclk);
    m_rcnt     = m_rcnt + radv;
    w_en       = we;
    wovf_clr   = clr;
    wsync_rptr = (ASIZE+1)'(m_rcnt % PMOD);
    if (we && m_full)  m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    if (we && !m_full) m_wcnt = m_wcnt + 1;
    m_full = ((m_wcnt - m_rcnt) == DEPTH);
    q.push_back(model_view(tag));
  endtask

  // reset pulse placed between clock edges
  task automatic reset_pulse(input string tag);
    @(negedge wclk);
    #2;
    wrst_n     = 1'b0;
    w_en       = 1'b0;
    wovf_clr   = 1'b0;
    wsync_rptr = '0;
    m_wcnt = 0;
    m_rcnt = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    q.push_back(model_view(tag));
    #1;
    -> ev_async;
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n     = 1'b0;
    w_en       = 1'b0;
    wovf_clr   = 1'b0;
    wsync_rptr = '0;

    reset_pulse("reset");

    // fill: four writes, full on the edge that takes the last slot
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0, "fill");

    // overflow: writes while full are ignored, flag is sticky
    cycle(1'b1, 0, 1'b0, "ovf_w1");
    cycle(1'b1, 0, 1'b0, "ovf_w2");
    cycle(1'b0, 0, 1'b1, "ovf_clr");
    cycle(1'b1, 0, 1'b1, "ovf_set_wins");
    cycle(1'b0, 0, 1'b1, "ovf_clr2");

    // drain then wrap the pointer
    cycle(1'b0, 4, 1'b0, "drain");
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0, "wrap");
    cycle(1'b1, 0, 1'b0, "wrap_stall");

    // almost-full
    reset_pulse("reset_af");
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b0, "afull_fill");
    cycle(1'b0, 1, 1'b0, "afull_drop");

    // reset in the middle of filling
    reset_pulse("reset_pre");
    cycle(1'b1, 0, 1'b0, "midfill");
    cycle(1'b1, 0, 1'b0, "midfill");
    reset_pulse("reset_mid");
    cycle(1'b1, 0, 1'b0, "post_reset_wr");
    cycle(1'b0, 0, 1'b0, "post_reset_idle");

    // randomized traffic with a reader that lags arbitrarily
    for (int i = 0; i < 400; i++) begin
      bit we;
      bit clr;
      int radv;
      int outst;
      we    = ($urandom % 10) < 7;
      clr   = ($urandom % 8) == 0;
      outst = m_wcnt - m_rcnt;
      radv  = (($urandom % 3) == 0) ? int'($urandom_range(0, outst)) : 0;
      cycle(we, radv, clr, "random");
      if (($urandom % 97) == 0) reset_pulse("reset_rand");
    end

    repeat (3) @(posedge wclk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
